// File: rtl/nn_pkg.sv
// Shared classifier definitions: class count, score width, packer states and
// the signed saturation helper used when SCORE_SAT_EN is defined.
package nn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 26;
    localparam int CLASS_IDX_W = 4;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        PRESENT  = 2'd1,
        WAIT_RES = 2'd2
    } state_e;

    typedef struct packed {
        logic               sat;
        logic [SCORE_W-1:0] score;
    } sat_res_t;

    // Clamp a sign-extended accumulator value into the signed SCORE_W range.
    function automatic sat_res_t saturate(input logic signed [63:0] v);
        sat_res_t           r;
        logic signed [63:0] smax;
        logic signed [63:0] smin;
        smax = (64'sd1 <<< (SCORE_W - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (SCORE_W - 1));
        if (v > smax) begin
            r.sat   = 1'b1;
            r.score = {1'b0, {(SCORE_W-1){1'b1}}};
        end else if (v < smin) begin
            r.sat   = 1'b1;
            r.score = {1'b1, {(SCORE_W-1){1'b0}}};
        end else begin
            r.sat   = 1'b0;
            r.score = v[SCORE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/score_sat.sv
// Accumulator-to-score conversion: truncation by default, signed saturation
// with a saturation flag when SCORE_SAT_EN is defined.
module score_sat #(
    parameter int ACC_W   = 32,
    parameter int SCORE_W = 26
) (
    input  logic [ACC_W-1:0]   acc_i,
    output logic [SCORE_W-1:0] score_o,
    output logic               sat_o
);
    import nn_pkg::*;

`ifdef SCORE_SAT_EN
    logic signed [63:0] acc_ext_s;
    sat_res_t           res_s;

    // Sign-extend and clamp through the shared helper.
    always_comb begin
        acc_ext_s = 64'(signed'(acc_i));
        res_s     = saturate(acc_ext_s);
        score_o   = res_s.score;
        sat_o     = res_s.sat;
    end
`else
    logic unused_hi_s;

    // Upper accumulator bits are simply discarded.
    always_comb begin
        score_o     = acc_i[SCORE_W-1:0];
        sat_o       = 1'b0;
        unused_hi_s = ^acc_i[ACC_W-1:SCORE_W];
    end
`endif

endmodule

// File: rtl/score_frame_packer.sv
// Collects ten serial class accumulators into held scores, strobes the max
// selector and registers its winning digit. Optional macro: SCORE_SAT_EN.
module score_frame_packer #(
    parameter int ACC_W       = 32,
    parameter int SCORE_W     = 26,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ACC_W-1:0]   acc_in,
    input  logic               acc_valid,
    input  logic               acc_last,
    output logic               acc_ready,
    output logic [SCORE_W-1:0] s0,
    output logic [SCORE_W-1:0] s1,
    output logic [SCORE_W-1:0] s2,
    output logic [SCORE_W-1:0] s3,
    output logic [SCORE_W-1:0] s4,
    output logic [SCORE_W-1:0] s5,
    output logic [SCORE_W-1:0] s6,
    output logic [SCORE_W-1:0] s7,
    output logic [SCORE_W-1:0] s8,
    output logic [SCORE_W-1:0] s9,
    output logic               scores_valid,
    input  logic               result_valid,
    input  logic [3:0]         img_num_in,
    output logic [3:0]         digit,
    output logic               digit_valid,
    output logic               frame_err
);
    import nn_pkg::*;

    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CLASS_IDX_W-1:0] LAST_IDX  = CLASS_IDX_W'(NUM_CLASSES - 1);
    localparam logic [WAIT_W-1:0]      WAIT_TERM = WAIT_W'(TIMEOUT_CYC - 1);

    state_e                   state_q, state_d;
    logic [CLASS_IDX_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic [SCORE_W-1:0]       slot_q [NUM_CLASSES];
    logic [SCORE_W-1:0]       slot_d [NUM_CLASSES];
    logic                     sat_seen_q, sat_seen_d;
    logic                     acc_ready_q, acc_ready_d;
    logic                     scores_valid_q, scores_valid_d;
    logic [CLASS_IDX_W-1:0]   digit_q, digit_d;
    logic                     digit_valid_q, digit_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic [SCORE_W-1:0]       score_s;
    logic                     sat_s;

    score_sat #(.ACC_W(ACC_W), .SCORE_W(SCORE_W)) u_score_sat (
        .acc_i   (acc_in),
        .score_o (score_s),
        .sat_o   (sat_s)
    );

    // Next-state and registered-output computation for the whole frame cycle.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wait_d         = wait_q;
        slot_d         = slot_q;
        sat_seen_d     = sat_seen_q;
        scores_valid_d = 1'b0;
        digit_d        = digit_q;
        digit_valid_d  = 1'b0;
        frame_err_d    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (acc_valid && acc_ready_q) begin
                    if (acc_last && (cnt_q == LAST_IDX)) begin
                        slot_d[cnt_q]  = score_s;
                        scores_valid_d = 1'b1;
                        frame_err_d    = sat_seen_q | sat_s;
                        sat_seen_d     = 1'b0;
                        cnt_d          = '0;
                        state_d        = PRESENT;
                    end else if (acc_last || (cnt_q == LAST_IDX)) begin
                        // Misframed beat: drop it and restart the frame.
                        frame_err_d = 1'b1;
                        sat_seen_d  = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        slot_d[cnt_q] = score_s;
                        sat_seen_d    = sat_seen_q | sat_s;
                        cnt_d         = cnt_q + CLASS_IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            PRESENT: begin
                wait_d  = '0;
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (result_valid) begin
                    digit_d       = img_num_in;
                    digit_valid_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = COLLECT;
                end else if (wait_q == WAIT_TERM) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = COLLECT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = COLLECT;
            end
        endcase
        acc_ready_d = (state_d == COLLECT);
    end

    // State and output registers; ready stays low while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= COLLECT;
            cnt_q          <= '0;
            wait_q         <= '0;
            slot_q         <= '{default: '0};
            sat_seen_q     <= 1'b0;
            acc_ready_q    <= 1'b0;
            scores_valid_q <= 1'b0;
            digit_q        <= '0;
            digit_valid_q  <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wait_q         <= wait_d;
            slot_q         <= slot_d;
            sat_seen_q     <= sat_seen_d;
            acc_ready_q    <= acc_ready_d;
            scores_valid_q <= scores_valid_d;
            digit_q        <= digit_d;
            digit_valid_q  <= digit_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign acc_ready    = acc_ready_q;
    assign scores_valid = scores_valid_q;
    assign digit        = digit_q;
    assign digit_valid  = digit_valid_q;
    assign frame_err    = frame_err_q;
    assign s0 = slot_q[0];
    assign s1 = slot_q[1];
    assign s2 = slot_q[2];
    assign s3 = slot_q[3];
    assign s4 = slot_q[4];
    assign s5 = slot_q[5];
    assign s6 = slot_q[6];
    assign s7 = slot_q[7];
    assign s8 = slot_q[8];
    assign s9 = slot_q[9];

endmodule

// File: tb/tb_score_frame_packer.sv
// Randomized self-checking bench for score_frame_packer against a
// slot-array reference model of the frame rules.
module tb_score_frame_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] acc_in;
    logic        acc_valid, acc_last, acc_ready;
    logic [25:0] s0, s1, s2, s3, s4, s5, s6, s7, s8, s9;
    logic        scores_valid, result_valid;
    logic [3:0]  img_num_in, digit;
    logic        digit_valid, frame_err;

    int errors = 0;
    int checks = 0;

    logic [25:0] exp_s [10];
    logic [25:0] s_obs [10];
    logic [3:0]  exp_digit;
    int          m_cnt;
    bit          m_sat;

    score_frame_packer dut (
        .clk(clk), .rst(rst), .acc_in(acc_in), .acc_valid(acc_valid),
        .acc_last(acc_last), .acc_ready(acc_ready),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4),
        .s5(s5), .s6(s6), .s7(s7), .s8(s8), .s9(s9),
        .scores_valid(scores_valid), .result_valid(result_valid),
        .img_num_in(img_num_in), .digit(digit), .digit_valid(digit_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign s_obs[0] = s0; assign s_obs[1] = s1; assign s_obs[2] = s2;
    assign s_obs[3] = s3; assign s_obs[4] = s4; assign s_obs[5] = s5;
    assign s_obs[6] = s6; assign s_obs[7] = s7; assign s_obs[8] = s8;
    assign s_obs[9] = s9;

    function automatic bit oversize(input logic [31:0] a);
        longint v;
        v = longint'($signed(a));
        return (v > 64'sd33554431) || (v < -64'sd33554432);
    endfunction

    function automatic logic [25:0] conv(input logic [31:0] a);
        longint v;
        v = longint'($signed(a));
`ifdef SCORE_SAT_EN
        if (v > 64'sd33554431)  return 26'h1FF_FFFF;
        if (v < -64'sd33554432) return 26'h200_0000;
`endif
        return a[25:0];
    endfunction

    function automatic logic [31:0] rand_acc();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 4000)) - 32'd2000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive n beats back to back; model reports what the final beat should cause.
    task automatic drive_beats(input logic [31:0] vals [10], input int n, input int last_at,
                               output bit e_sv, output bit e_err);
        e_sv = 1'b0; e_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc_valid = 1'b1; acc_in = vals[i]; acc_last = (i + 1 == last_at);
            e_sv = 1'b0; e_err = 1'b0;
            if (acc_last && m_cnt == 9) begin
                exp_s[9] = conv(vals[i]);
                e_sv = 1'b1;
`ifdef SCORE_SAT_EN
                e_err = m_sat | oversize(vals[i]);
`endif
                m_sat = 1'b0; m_cnt = 0;
            end else if (acc_last || m_cnt == 9) begin
                e_err = 1'b1; m_sat = 1'b0; m_cnt = 0;
            end else begin
                exp_s[m_cnt] = conv(vals[i]);
                m_sat = m_sat | oversize(vals[i]);
                m_cnt++;
            end
            step();
        end
        acc_valid = 1'b0; acc_last = 1'b0;
    endtask

    // From the scores_valid cycle: wait d WAIT_RES cycles, then return dig.
    task automatic drive_result(input logic [3:0] dig, input int d);
        result_valid = 1'b0;
        step();
        repeat (d) step();
        result_valid = 1'b1; img_num_in = dig;
        step();
        result_valid = 1'b0;
        exp_digit = dig;
    endtask

    task automatic test_reset();
        rst = 1'b1; acc_valid = 1'b0; acc_last = 1'b0; acc_in = '0;
        result_valid = 1'b0; img_num_in = '0;
        m_cnt = 0; m_sat = 1'b0; exp_digit = '0;
        for (int i = 0; i < 10; i++) exp_s[i] = '0;
        step(); step();
        checks++;
        if ({acc_ready, scores_valid, digit_valid, frame_err, digit} !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got %b required 00000000",
                               {acc_ready, scores_valid, digit_valid, frame_err, digit});
        end
        rst = 1'b0;
        step();
        checks++;
        if (acc_ready !== 1'b1 || scores_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release: ready=%b sv=%b required 1/0", acc_ready, scores_valid);
        end
    endtask

    task automatic test_classify_fixed();
        logic [31:0] v [10];
        bit e_sv, e_err;
        v = '{32'd100, -32'sd5, 32'd7, 32'd3000, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, -32'sd9};
        drive_beats(v, 10, 10, e_sv, e_err);
        checks++;
        if (scores_valid !== 1'b1 || acc_ready !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL fixed_present: sv=%b ready=%b err=%b required 1/0/0",
                               scores_valid, acc_ready, frame_err);
        end
        checks++;
        if (s3 !== 26'd3000 || s9 !== 26'h3FF_FFF7) begin
            errors++; $display("FAIL fixed_scores: s3=%h s9=%h required bb8/3fffff7", s3, s9);
        end
        result_valid = 1'b1; img_num_in = 4'd7;
        step();
        result_valid = 1'b0;
        checks++;
        if (scores_valid !== 1'b0 || digit_valid !== 1'b0) begin
            errors++; $display("FAIL fixed_stale: sv=%b dv=%b required 0/0", scores_valid, digit_valid);
        end
        step(); step();
        result_valid = 1'b1; img_num_in = 4'd3;
        step();
        result_valid = 1'b0; exp_digit = 4'd3;
        checks++;
        if (digit_valid !== 1'b1 || digit !== 4'd3) begin
            errors++; $display("FAIL fixed_digit: dv=%b digit=%0d required 1/3", digit_valid, digit);
        end
        step();
        checks++;
        if (digit_valid !== 1'b0 || acc_ready !== 1'b1) begin
            errors++; $display("FAIL fixed_pulse: dv=%b ready=%b required 0/1", digit_valid, acc_ready);
        end
    endtask

    task automatic test_random_frames();
        logic [31:0] v [10];
        bit e_sv, e_err;
        logic [3:0] dig;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 10; i++) v[i] = rand_acc();
            result_valid = 1'b1; img_num_in = 4'($urandom_range(0, 15));
            drive_beats(v, 10, 10, e_sv, e_err);
            result_valid = 1'b0;
            checks++;
            if (scores_valid !== e_sv || frame_err !== e_err || digit !== exp_digit || digit_valid !== 1'b0) begin
                errors++; $display("FAIL rand_present[%0d]: sv=%b err=%b digit=%0d dv=%b required %b/%b/%0d/0",
                                   f, scores_valid, frame_err, digit, digit_valid, e_sv, e_err, exp_digit);
            end
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (s_obs[i] !== exp_s[i]) begin
                    errors++; $display("FAIL rand_score[%0d] s%0d: got %h required %h", f, i, s_obs[i], exp_s[i]);
                end
            end
            dig = 4'($urandom_range(0, 9));
            drive_result(dig, $urandom_range(0, 13));
            checks++;
            if (digit_valid !== 1'b1 || digit !== dig || frame_err !== 1'b0) begin
                errors++; $display("FAIL rand_digit[%0d]: dv=%b digit=%0d err=%b required 1/%0d/0",
                                   f, digit_valid, digit, frame_err, dig);
            end
        end
    endtask

    task automatic test_protocol_err();
        logic [31:0] v [10];
        bit e_sv, e_err;
        for (int i = 0; i < 10; i++) v[i] = 32'($urandom_range(0, 999));
        drive_beats(v, 6, 6, e_sv, e_err);
        checks++;
        if (frame_err !== 1'b1 || scores_valid !== 1'b0 || acc_ready !== 1'b1) begin
            errors++; $display("FAIL early_last: err=%b sv=%b ready=%b required 1/0/1", frame_err, scores_valid, acc_ready);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (s_obs[i] !== exp_s[i]) begin
                errors++; $display("FAIL early_last_slots s%0d: got %h required %h", i, s_obs[i], exp_s[i]);
            end
        end
        drive_beats(v, 10, 0, e_sv, e_err);
        checks++;
        if (frame_err !== 1'b1 || scores_valid !== 1'b0) begin
            errors++; $display("FAIL missing_last: err=%b sv=%b required 1/0", frame_err, scores_valid);
        end
        for (int i = 0; i < 10; i++) v[i] = rand_acc();
        drive_beats(v, 10, 10, e_sv, e_err);
        checks++;
        if (scores_valid !== 1'b1 || frame_err !== e_err || s7 !== exp_s[7]) begin
            errors++; $display("FAIL recover_frame: sv=%b err=%b s7=%h required 1/%b/%h",
                               scores_valid, frame_err, s7, e_err, exp_s[7]);
        end
        drive_result(4'd8, 2);
        checks++;
        if (digit_valid !== 1'b1 || digit !== 4'd8) begin
            errors++; $display("FAIL recover_digit: dv=%b digit=%0d required 1/8", digit_valid, digit);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] v [10];
        bit e_sv, e_err;
        for (int i = 0; i < 10; i++) v[i] = 32'(i * 11);
        drive_beats(v, 10, 10, e_sv, e_err);
        step();
        for (int k = 1; k <= 15; k++) begin
            step();
            checks++;
            if (frame_err !== (k == 15) || digit_valid !== 1'b0) begin
                errors++; $display("FAIL timeout_wait[%0d]: err=%b dv=%b required %b/0", k, frame_err, digit_valid, k == 15);
            end
        end
        checks++;
        if (acc_ready !== 1'b1 || digit !== exp_digit) begin
            errors++; $display("FAIL timeout_exit: ready=%b digit=%0d required 1/%0d", acc_ready, digit, exp_digit);
        end
        step();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse: err=%b required 0", frame_err);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] v [10];
        bit e_sv, e_err;
        for (int i = 0; i < 10; i++) v[i] = 32'($urandom_range(0, 99));
        v[2] = 32'h7FFF_FFFF;
        v[5] = 32'h8000_0000;
        drive_beats(v, 10, 10, e_sv, e_err);
`ifdef SCORE_SAT_EN
        checks++;
        if (s2 !== 26'h1FF_FFFF || s5 !== 26'h200_0000 || frame_err !== 1'b1) begin
            errors++; $display("FAIL sat_clamp: s2=%h s5=%h err=%b required 1ffffff/2000000/1", s2, s5, frame_err);
        end
`else
        checks++;
        if (s2 !== 26'h3FF_FFFF || s5 !== 26'h000_0000 || frame_err !== 1'b0) begin
            errors++; $display("FAIL sat_trunc: s2=%h s5=%h err=%b required 3ffffff/0000000/0", s2, s5, frame_err);
        end
`endif
        drive_result(4'd2, 0);
        checks++;
        if (digit_valid !== 1'b1 || digit !== 4'd2) begin
            errors++; $display("FAIL sat_digit: dv=%b digit=%0d required 1/2", digit_valid, digit);
        end
    endtask

    task automatic test_coincident();
        logic [31:0] v [10];
        bit e_sv, e_err;
        logic [3:0] dig;
        for (int i = 0; i < 10; i++) v[i] = rand_acc();
        drive_beats(v, 10, 10, e_sv, e_err);
        dig = 4'($urandom_range(0, 9));
        drive_result(dig, 14);
        checks++;
        if (digit_valid !== 1'b1 || digit !== dig || frame_err !== 1'b0) begin
            errors++; $display("FAIL coincident: dv=%b digit=%0d err=%b required 1/%0d/0", digit_valid, digit, frame_err, dig);
        end
        step();
        checks++;
        if (frame_err !== 1'b0 || acc_ready !== 1'b1) begin
            errors++; $display("FAIL coincident_after: err=%b ready=%b required 0/1", frame_err, acc_ready);
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] v [10];
        bit e_sv, e_err;
        for (int i = 0; i < 10; i++) v[i] = 32'(i + 500);
        drive_beats(v, 10, 10, e_sv, e_err);
        step(); step();
        rst = 1'b1;
        #1;
        m_cnt = 0; m_sat = 1'b0; exp_digit = '0;
        for (int i = 0; i < 10; i++) exp_s[i] = '0;
        checks++;
        if ({acc_ready, scores_valid, digit_valid, frame_err, digit} !== 8'h00 || s4 !== 26'd0 || s9 !== 26'd0) begin
            errors++; $display("FAIL reset_wait: flags=%b s4=%h s9=%h required 0",
                               {acc_ready, scores_valid, digit_valid, frame_err, digit}, s4, s9);
        end
        step();
        rst = 1'b0;
        result_valid = 1'b1; img_num_in = 4'd5;
        repeat (3) step();
        result_valid = 1'b0;
        checks++;
        if (digit_valid !== 1'b0 || digit !== 4'd0 || acc_ready !== 1'b1) begin
            errors++; $display("FAIL late_result: dv=%b digit=%0d ready=%b required 0/0/1", digit_valid, digit, acc_ready);
        end
        for (int i = 0; i < 10; i++) v[i] = rand_acc();
        drive_beats(v, 10, 10, e_sv, e_err);
        checks++;
        if (scores_valid !== 1'b1 || s0 !== exp_s[0] || s9 !== exp_s[9]) begin
            errors++; $display("FAIL post_reset_frame: sv=%b s0=%h s9=%h required 1/%h/%h",
                               scores_valid, s0, s9, exp_s[0], exp_s[9]);
        end
        drive_result(4'd6, 1);
        checks++;
        if (digit_valid !== 1'b1 || digit !== 4'd6) begin
            errors++; $display("FAIL post_reset_digit: dv=%b digit=%0d required 1/6", digit_valid, digit);
        end
    endtask

    initial begin
        test_reset();
        test_classify_fixed();
        test_random_frames();
        test_protocol_err();
        test_timeout();
        test_saturation();
        test_coincident();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
